// File: rtl/vram_ctrl_pkg.sv
// rtl/vram_ctrl_pkg.sv - shared types, constants and clipping helpers for the sketch VRAM writer
//
// Purpose: common definitions for vram_sketch_controller and vram_rect_scanner.
//   vram_ctrl_state_t : job sequencer states
//   VRAM_ADDR_W       : VRAM address width for the default 240x320 panel
//   vram_rect_t       : inclusive pixel rectangle plus the linear address of its first row
//   ILI9341_color_t   : RGB565 pixel colour
//   touch_t           : touch report (valid, x, y)
package vram_ctrl_pkg;

    localparam int DISPLAY_W   = 240;
    localparam int DISPLAY_H   = 320;
    localparam int COORD_W     = 9;
    localparam int VRAM_ADDR_W = $clog2(DISPLAY_W * DISPLAY_H);

    typedef logic [15:0] ILI9341_color_t;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } touch_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        CAPTURE,
        BRUSH
    } vram_ctrl_state_t;

    typedef struct packed {
        logic [COORD_W-1:0]     x0;
        logic [COORD_W-1:0]     x1;
        logic [COORD_W-1:0]     y0;
        logic [COORD_W-1:0]     y1;
        logic [VRAM_ADDR_W-1:0] row_base;
    } vram_rect_t;

    function automatic vram_rect_t full_rect(input int w, input int h);
        vram_rect_t rc;
        rc.x0       = '0;
        rc.x1       = COORD_W'(w - 1);
        rc.y0       = '0;
        rc.y1       = COORD_W'(h - 1);
        rc.row_base = '0;
        return rc;
    endfunction

    // Square of half-size r around (x,y), clipped to the screen. The low edge
    // uses a compare instead of a subtraction that could borrow; the high edge
    // is computed one bit wider so x+r cannot wrap before the clamp.
    function automatic vram_rect_t brush_rect(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y,
                                              input int w, input int h, input int r);
        vram_rect_t       rc;
        logic [COORD_W:0] r_ext;
        logic [COORD_W:0] w_max;
        logic [COORD_W:0] h_max;
        logic [COORD_W:0] x_hi;
        logic [COORD_W:0] y_hi;
        r_ext       = (COORD_W + 1)'(r);
        w_max       = (COORD_W + 1)'(w - 1);
        h_max       = (COORD_W + 1)'(h - 1);
        x_hi        = {1'b0, x} + r_ext;
        y_hi        = {1'b0, y} + r_ext;
        rc.x0       = ({1'b0, x} >= r_ext) ? (x - r_ext[COORD_W-1:0]) : '0;
        rc.y0       = ({1'b0, y} >= r_ext) ? (y - r_ext[COORD_W-1:0]) : '0;
        rc.x1       = (x_hi > w_max) ? w_max[COORD_W-1:0] : x_hi[COORD_W-1:0];
        rc.y1       = (y_hi > h_max) ? h_max[COORD_W-1:0] : y_hi[COORD_W-1:0];
        rc.row_base = VRAM_ADDR_W'(rc.y0) * VRAM_ADDR_W'(w);
        return rc;
    endfunction

endpackage

// File: rtl/vram_rect_scanner.sv
// rtl/vram_rect_scanner.sv - row-major rectangle write generator, one pixel per cycle
//
// Purpose: emits one registered VRAM write per cycle covering a rectangle.
//   clk_i, rst_i : clock, synchronous active-high reset (arms a full-screen clear)
//   start_i      : load rect_i/color_i and emit its first pixel at this clock edge
//   abort_i      : drop the job in progress (start_i in the same cycle still wins)
//   rect_i       : rectangle bounds and first-row base address
//   color_i      : data written to every pixel of the job
//   wr_ena_o, wr_addr_o, wr_data_o : registered write port
//   last_o       : high together with the final write of a job
module vram_rect_scanner
    import vram_ctrl_pkg::*;
#(
    parameter int             WIDTH       = DISPLAY_W,
    parameter int             HEIGHT      = DISPLAY_H,
    parameter ILI9341_color_t CLEAR_COLOR = 16'h0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  vram_rect_t             rect_i,
    input  ILI9341_color_t         color_i,
    output logic                   wr_ena_o,
    output logic [VRAM_ADDR_W-1:0] wr_addr_o,
    output ILI9341_color_t         wr_data_o,
    output logic                   last_o
);

    logic                   active_q;
    logic [COORD_W-1:0]     x0_q, x1_q, y1_q, cx_q, cy_q;
    logic [VRAM_ADDR_W-1:0] base_q;
    ILI9341_color_t         color_q;
    logic                   wr_ena_q, last_q;
    logic [VRAM_ADDR_W-1:0] wr_addr_q;
    ILI9341_color_t         wr_data_q;

    logic                   go, end_row, end_rect, active_d;
    logic [COORD_W-1:0]     cur_x0, cur_x1, cur_y1, cur_x, cur_y, cx_d, cy_d;
    logic [VRAM_ADDR_W-1:0] cur_base, base_d, addr_d;
    ILI9341_color_t         cur_color;

    // The counters hold the next pixel to emit; a start overrides them so the
    // first pixel of a new job goes out on the very edge that sees start_i.
    always_comb begin
        go        = active_q & ~abort_i;
        cur_x0    = x0_q;
        cur_x1    = x1_q;
        cur_y1    = y1_q;
        cur_x     = cx_q;
        cur_y     = cy_q;
        cur_base  = base_q;
        cur_color = color_q;
        if (start_i) begin
            go        = 1'b1;
            cur_x0    = rect_i.x0;
            cur_x1    = rect_i.x1;
            cur_y1    = rect_i.y1;
            cur_x     = rect_i.x0;
            cur_y     = rect_i.y0;
            cur_base  = rect_i.row_base;
            cur_color = color_i;
        end
        end_row  = (cur_x == cur_x1);
        end_rect = end_row && (cur_y == cur_y1);
        cx_d     = end_row ? cur_x0 : cur_x + COORD_W'(1);
        cy_d     = end_row ? cur_y + COORD_W'(1) : cur_y;
        // Next row's base is one full line further on, so no multiply per row.
        base_d   = end_row ? cur_base + VRAM_ADDR_W'(WIDTH) : cur_base;
        active_d = go & ~end_rect;
        addr_d   = cur_base + VRAM_ADDR_W'(cur_x);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q  <= 1'b1;
            x0_q      <= '0;
            x1_q      <= COORD_W'(WIDTH - 1);
            y1_q      <= COORD_W'(HEIGHT - 1);
            cx_q      <= '0;
            cy_q      <= '0;
            base_q    <= '0;
            color_q   <= CLEAR_COLOR;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= CLEAR_COLOR;
            last_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            wr_ena_q <= go;
            last_q   <= go & end_rect;
            if (go) begin
                x0_q      <= cur_x0;
                x1_q      <= cur_x1;
                y1_q      <= cur_y1;
                cx_q      <= cx_d;
                cy_q      <= cy_d;
                base_q    <= base_d;
                color_q   <= cur_color;
                wr_addr_q <= addr_d;
                wr_data_q <= cur_color;
            end
        end
    end

    assign wr_ena_o  = wr_ena_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign last_o    = last_q;

endmodule

// File: rtl/vram_sketch_controller.sv
// rtl/vram_sketch_controller.sv - sole VRAM writer: screen clear and clipped brush stamps
//
// Purpose: sequences full-screen clears and square brush stamps into the VRAM write port.
//   clk, rst     : clock, synchronous active-high reset (starts a clear)
//   clear_req    : level; starts or restarts a clear
//   touch        : touch report (valid, x, y)
//   draw_color   : brush colour, sampled when a stamp is accepted
//   vram_wr_ena, vram_wr_addr, vram_wr_data : registered VRAM write port
//   busy         : high in CLEAR, CAPTURE and BRUSH
//   clear_done   : one-cycle pulse after the last clear write
module vram_sketch_controller
    import vram_ctrl_pkg::*;
#(
    parameter int             DISPLAY_WIDTH  = 240,
    parameter int             DISPLAY_HEIGHT = 320,
    parameter int             VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int             BRUSH_R        = 2,
    parameter ILI9341_color_t CLEAR_COLOR    = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_req,
    input  touch_t                    touch,
    input  ILI9341_color_t            draw_color,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output ILI9341_color_t            vram_wr_data,
    output logic                      busy,
    output logic                      clear_done
);

    vram_ctrl_state_t       state_q, state_d;
    logic [COORD_W-1:0]     pt_x_q, pt_y_q;
    logic                   released_q;
    ILI9341_color_t         color_q;
    vram_rect_t             rect_q;
    logic                   brush_go_q;
    logic                   clear_done_q;

    logic                   in_range, new_point, touch_ok;
    logic                   scan_start, scan_abort;
    vram_rect_t             scan_rect;
    ILI9341_color_t         scan_color;
    logic                   scan_ena, scan_last;
    logic [VRAM_ADDR_W-1:0] scan_addr;
    ILI9341_color_t         scan_data;

    // A held touch only re-stamps once it moves or has been lifted in between.
    always_comb begin
        in_range  = (touch.x < COORD_W'(DISPLAY_WIDTH)) && (touch.y < COORD_W'(DISPLAY_HEIGHT));
        new_point = (touch.x != pt_x_q) || (touch.y != pt_y_q) || released_q;
        touch_ok  = touch.valid && in_range && new_point;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_req) begin
            state_d = CLEAR;
        end else begin
            case (state_q)
                CLEAR:   if (scan_last) state_d = IDLE;
                IDLE:    if (touch_ok)  state_d = CAPTURE;
                CAPTURE: state_d = BRUSH;
                BRUSH:   if (scan_last) state_d = IDLE;
                default: state_d = CLEAR;
            endcase
        end
    end

    // clear_req restarts the scanner directly, so address 0 is written on the
    // edge that samples the request, whatever job was running.
    always_comb begin
        busy       = (state_q != IDLE);
        scan_start = clear_req | brush_go_q;
        scan_abort = clear_req;
        scan_rect  = clear_req ? full_rect(DISPLAY_WIDTH, DISPLAY_HEIGHT) : rect_q;
        scan_color = clear_req ? CLEAR_COLOR : color_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pt_x_q       <= '0;
            pt_y_q       <= '0;
            released_q   <= 1'b1;
            color_q      <= CLEAR_COLOR;
            rect_q       <= full_rect(DISPLAY_WIDTH, DISPLAY_HEIGHT);
            brush_go_q   <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            clear_done_q <= (state_q == CLEAR) && scan_last && !clear_req;
            brush_go_q   <= (state_q == CAPTURE) && (state_d == BRUSH);
            if ((state_q == IDLE) && (state_d == CAPTURE)) begin
                pt_x_q     <= touch.x;
                pt_y_q     <= touch.y;
                color_q    <= draw_color;
                released_q <= 1'b0;
            end else if (!touch.valid) begin
                released_q <= 1'b1;
            end
            if (state_q == CAPTURE) begin
                rect_q <= brush_rect(pt_x_q, pt_y_q, DISPLAY_WIDTH, DISPLAY_HEIGHT, BRUSH_R);
            end
        end
    end

    vram_rect_scanner #(
        .WIDTH       (DISPLAY_WIDTH),
        .HEIGHT      (DISPLAY_HEIGHT),
        .CLEAR_COLOR (CLEAR_COLOR)
    ) u_scanner (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (scan_start),
        .abort_i   (scan_abort),
        .rect_i    (scan_rect),
        .color_i   (scan_color),
        .wr_ena_o  (scan_ena),
        .wr_addr_o (scan_addr),
        .wr_data_o (scan_data),
        .last_o    (scan_last)
    );

    assign vram_wr_ena  = scan_ena;
    assign vram_wr_addr = scan_addr;
    assign vram_wr_data = scan_data;
    assign clear_done   = clear_done_q;

endmodule

// File: tb/tb_vram_sketch_controller.sv
// tb/tb_vram_sketch_controller.sv - self-checking bench for vram_sketch_controller
`timescale 1ns/1ps
module tb_vram_sketch_controller;
    import vram_ctrl_pkg::*;

    localparam int W = 240;
    localparam int H = 320;
    localparam int R = 2;
    localparam int L = W * H;
    localparam logic [15:0] CLR = 16'h0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clear_req;
    touch_t                 touch;
    ILI9341_color_t         draw_color;
    logic                   vram_wr_ena;
    logic [$clog2(L)-1:0]   vram_wr_addr;
    ILI9341_color_t         vram_wr_data;
    logic                   busy;
    logic                   clear_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int got_a[$];
    int got_d[$];
    int got_c[$];
    int exp_a[$];
    int busy_fall;
    bit timed_out;

    vram_sketch_controller #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .VRAM_L         (L),
        .BRUSH_R        (R),
        .CLEAR_COLOR    (CLR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear_req    (clear_req),
        .touch        (touch),
        .draw_color   (draw_color),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference stamp: every on-screen pixel within R of (x,y), row-major.
    task automatic model_stamp(input int x, input int y);
        int xlo, xhi, ylo, yhi;
        xlo = (x - R < 0) ? 0 : x - R;
        xhi = (x + R > W - 1) ? W - 1 : x + R;
        ylo = (y - R < 0) ? 0 : y - R;
        yhi = (y + R > H - 1) ? H - 1 : y + R;
        exp_a.delete();
        for (int yy = ylo; yy <= yhi; yy++)
            for (int xx = xlo; xx <= xhi; xx++)
                exp_a.push_back(yy * W + xx);
    endtask

    // Record writes until busy has risen and fallen again, within a cycle budget.
    task automatic collect(input int budget);
        bit seen_busy;
        seen_busy = 0;
        timed_out = 1;
        busy_fall = -1;
        got_a.delete();
        got_d.delete();
        got_c.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vram_wr_ena) begin
                got_a.push_back(int'(vram_wr_addr));
                got_d.push_back(int'(vram_wr_data));
                got_c.push_back(cyc);
            end
            if (busy) seen_busy = 1;
            else if (seen_busy) begin
                timed_out = 0;
                busy_fall = cyc;
                break;
            end
        end
    endtask

    task automatic stamp_and_check(input string tag, input int x, input int y, input logic [15:0] col);
        int t0, bad;
        touch.valid = 1'b1;
        touch.x     = COORD_W'(x);
        touch.y     = COORD_W'(y);
        draw_color  = col;
        t0          = cyc;
        collect(400);
        model_stamp(x, y);
        check({tag, " timeout"}, timed_out, 0);
        check({tag, " count"}, got_a.size(), exp_a.size());
        bad = 0;
        foreach (got_a[i])
            if (i >= exp_a.size() || got_a[i] != exp_a[i] || got_d[i] != int'(col) || got_c[i] != t0 + 3 + i)
                bad++;
        check({tag, " content"}, bad, 0);
        check({tag, " busy_fall"}, busy_fall, (got_c.size() > 0) ? got_c[got_c.size() - 1] + 1 : -2);
    endtask

    task automatic idle_window(input string tag, input int n);
        int writes, busy_hi;
        writes  = 0;
        busy_hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (vram_wr_ena) writes++;
            if (busy) busy_hi++;
        end
        check({tag, " writes"}, writes, 0);
        check({tag, " busy"}, busy_hi, 0);
    endtask

    initial begin
        int r, n, bad, done_n, done_cyc, done_busy;
        int corner[9];
        corner = '{0, 1, 2, 240, 241, 242, 480, 481, 482};

        rst        = 1'b1;
        clear_req  = 1'b0;
        touch      = '0;
        draw_color = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst ena", vram_wr_ena, 0);
        check("rst addr", vram_wr_addr, 0);
        check("rst data", vram_wr_data, CLR);
        check("rst busy", busy, 1);
        check("rst done", clear_done, 0);

        // Reset clear: L back-to-back writes from the first cycle after reset.
        rst       = 1'b0;
        r         = cyc;
        n         = 0;
        bad       = 0;
        done_n    = 0;
        done_cyc  = -1;
        done_busy = -1;
        for (int i = 0; i < L + 200; i++) begin
            @(negedge clk);
            if (vram_wr_ena) begin
                if (int'(vram_wr_addr) != n || vram_wr_data != CLR || cyc != r + 1 + n) bad++;
                n++;
            end
            if (clear_done) begin
                done_n++;
                done_cyc  = cyc;
                done_busy = busy;
            end
            if (done_n > 0 && cyc >= done_cyc + 3) break;
        end
        check("clear writes", n, L);
        check("clear order", bad, 0);
        check("clear done pulses", done_n, 1);
        check("clear done cycle", done_cyc, r + L + 1);
        check("clear done busy", done_busy, 0);

        // Interior and corner stamps.
        stamp_and_check("interior", 100, 50, 16'hF800);
        check("interior first", (got_a.size() > 0) ? got_a[0] : -1, 11618);
        check("interior last", (got_a.size() > 0) ? got_a[got_a.size() - 1] : -1, 12582);

        stamp_and_check("corner00", 0, 0, 16'h07E0);
        bad = 0;
        for (int i = 0; i < 9; i++)
            if (i >= got_a.size() || got_a[i] != corner[i]) bad++;
        check("corner00 list", bad, 0);

        stamp_and_check("corner_br", 239, 319, 16'h001F);
        check("corner_br last", (got_a.size() > 0) ? got_a[got_a.size() - 1] : -1, L - 1);

        // Dedup: held point stamps once; a move or a lift-and-retouch stamps again.
        stamp_and_check("hold first", 100, 50, 16'h1234);
        idle_window("hold 1000", 1000);
        stamp_and_check("move", 101, 50, 16'h4321);
        touch.valid = 1'b0;
        idle_window("release", 2);
        stamp_and_check("retouch", 101, 50, 16'hABCD);

        // Out-of-range points are ignored and leave the last point untouched.
        touch.x = COORD_W'(240);
        touch.y = COORD_W'(10);
        idle_window("x240", 30);
        touch.x = COORD_W'(5);
        touch.y = COORD_W'(320);
        idle_window("y320", 30);
        touch.x = COORD_W'(101);
        touch.y = COORD_W'(50);
        idle_window("back to last", 30);

        // Random stamps against the reference model.
        for (int k = 0; k < 10; k++) begin
            touch.valid = 1'b0;
            @(negedge clk);
            stamp_and_check($sformatf("rand%0d", k), int'($urandom_range(W - 1)),
                            int'($urandom_range(H - 1)), 16'($urandom));
        end

        // Abort: clear_req on the 10th stamp write restarts the clear at address 0.
        touch.valid = 1'b0;
        @(negedge clk);
        touch.valid = 1'b1;
        touch.x     = COORD_W'(100);
        touch.y     = COORD_W'(50);
        draw_color  = 16'hF800;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vram_wr_ena) n++;
            if (n == 10) break;
        end
        model_stamp(100, 50);
        check("abort reached 10th", n, 10);
        check("abort 10th addr", vram_wr_addr, exp_a[9]);
        clear_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort restart%0d ena", i), vram_wr_ena, 1);
            check($sformatf("abort restart%0d addr", i), vram_wr_addr, 0);
            check($sformatf("abort restart%0d data", i), vram_wr_data, CLR);
        end
        clear_req   = 1'b0;
        touch.valid = 1'b0;
        bad = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (!vram_wr_ena || int'(vram_wr_addr) != k || vram_wr_data != CLR || !busy || clear_done) bad++;
        end
        check("abort clear continues", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
